// File: rtl/wm_pack_pkg.sv
// ---------------------------------------------------------------------------
// wm_pack_pkg
//
// Shared watermark package. It holds the default geometry of a packed
// watermark stream, the occupancy states of the small output buffer and a
// ceiling-log2 helper used to size counters.
//
// Users: wm_pack, wm_pack_buf and the read-side nibble unpacker.
//
// Contents:
//   DEF_WM_BAND_WIDTH  width of one packed watermark word
//   DEF_DOP            nibble (lane) width of one input beat
//   DEF_WM_CNT         words per watermark frame
//   buf_state_t        occupancy of the 2-entry output buffer
//   clog2()            ceiling log2, never smaller than 1
// ---------------------------------------------------------------------------
package wm_pack_pkg;

    localparam int DEF_WM_BAND_WIDTH = 128;
    localparam int DEF_DOP           = 4;
    localparam int DEF_WM_CNT        = 313;

    // Occupancy of the 2-entry word buffer.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    // Ceiling log2. Counters are sized with clog2(max_count), so a counter
    // running 0..31 gets clog2(31) = 5 bits. The result is clamped to 1 so
    // that a degenerate range still yields a legal vector width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wm_pack_buf.sv
// ---------------------------------------------------------------------------
// wm_pack_buf
//
// Two-entry FIFO that sits between the nibble packer and the downstream
// word consumer. Entry 0 is always the head, so the head data comes straight
// from a register. A push together with a pop keeps the occupancy unchanged
// and preserves order.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset; empties the FIFO and zeroes
//               both data entries
//   clr         synchronous clear; empties the FIFO and keeps the data
//   push        write push_data at the tail
//   push_data   entry to write
//   pop         remove the head entry (ignored when empty)
//   head_data   head entry contents
//   head_valid  FIFO holds at least one entry
//   full        FIFO holds two entries
// ---------------------------------------------------------------------------
module wm_pack_buf
    import wm_pack_pkg::*;
#(
    parameter int WIDTH = DEF_WM_BAND_WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic             full
);

    buf_state_t       state;
    buf_state_t       state_nxt;
    logic [WIDTH-1:0] ent0;
    logic [WIDTH-1:0] ent1;
    logic             load0;
    logic             load1;
    logic             advance;

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= BUF_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next occupancy and entry write controls. load0 writes the head
    // directly, load1 writes the second slot, and advance moves the second
    // slot into the head. A clear overrides any push or pop in the same
    // cycle.
    always_comb begin
        state_nxt = state;
        load0     = 1'b0;
        load1     = 1'b0;
        advance   = 1'b0;
        if (clr) begin
            state_nxt = BUF_EMPTY;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (push) begin
                        load0     = 1'b1;
                        state_nxt = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (push && pop) begin
                        load0 = 1'b1;
                    end else if (push) begin
                        load1     = 1'b1;
                        state_nxt = BUF_FULL;
                    end else if (pop) begin
                        state_nxt = BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    // The packer stalls while full. A push that arrives
                    // together with a pop is still handled in order.
                    if (pop) begin
                        advance = 1'b1;
                        if (push) begin
                            load1 = 1'b1;
                        end else begin
                            state_nxt = BUF_ONE;
                        end
                    end
                end
                default: begin
                    state_nxt = BUF_EMPTY;
                end
            endcase
        end
    end

    // Entry storage. Reset zeroes the data so the head reads as zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent0 <= '0;
            ent1 <= '0;
        end else begin
            if (load0) begin
                ent0 <= push_data;
            end else if (advance) begin
                ent0 <= ent1;
            end
            if (load1) begin
                ent1 <= push_data;
            end
        end
    end

    assign head_data  = ent0;
    assign head_valid = (state != BUF_EMPTY);
    assign full       = (state == BUF_FULL);

endmodule

// File: rtl/wm_pack.sv
// ---------------------------------------------------------------------------
// wm_pack
//
// Packs a stream of DOP-bit watermark nibbles into WM_BAND_WIDTH-bit words,
// LSB first. Completed words are tagged with a frame-last flag (word
// WM_CNT-1 of each frame) and queued in a 2-entry buffer for the downstream
// consumer.
//
// Ports:
//   clk           clock, rising edge
//   rst_n         synchronous active-low reset
//   i_done        synchronous frame abort/clear; discards the partial word
//                 and any buffered words
//   i_r_data      extracted watermark nibble
//   i_wea         i_r_data valid; the beat is accepted when o_rdy is high
//   o_rdy         nibble accept ready (low while the buffer is full)
//   o_w_data      packed word at the buffer head
//   o_w_valid     o_w_data valid
//   i_w_ready     downstream ready; a word is popped on o_w_valid && i_w_ready
//   o_w_last      head word is the last word of the frame
//   o_frame_done  one-cycle pulse after the last word of a frame is popped
// ---------------------------------------------------------------------------
module wm_pack
    import wm_pack_pkg::*;
#(
    parameter int WM_BAND_WIDTH = DEF_WM_BAND_WIDTH,
    parameter int DOP           = DEF_DOP,
    parameter int WM_CNT        = DEF_WM_CNT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_done,
    input  logic [DOP-1:0]           i_r_data,
    input  logic                     i_wea,
    output logic                     o_rdy,
    output logic [WM_BAND_WIDTH-1:0] o_w_data,
    output logic                     o_w_valid,
    input  logic                     i_w_ready,
    output logic                     o_w_last,
    output logic                     o_frame_done
);

    localparam int BEATS  = WM_BAND_WIDTH / DOP;
    localparam int NIB_W  = clog2(BEATS - 1);
    localparam int WORD_W = clog2(WM_CNT - 1);

    localparam logic [NIB_W-1:0]  NIB_LAST  = NIB_W'(BEATS - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WM_CNT - 1);

    logic [NIB_W-1:0]         nib_cnt;
    logic [WORD_W-1:0]        word_cnt;
    logic [WM_BAND_WIDTH-1:0] shreg;
    logic [WM_BAND_WIDTH-1:0] full_word;
    logic [WM_BAND_WIDTH-1:0] head_word;
    logic                     head_last;
    logic                     head_valid;
    logic                     buf_full;
    logic                     accept;
    logic                     last_beat;
    logic                     push;
    logic                     pop;
    logic                     frame_done_q;

    assign o_rdy     = !buf_full;
    assign accept    = i_wea && o_rdy;
    assign last_beat = accept && (nib_cnt == NIB_LAST);

    // i_done wins over a simultaneous final beat or pop.
    assign push = last_beat && !i_done;
    assign pop  = head_valid && i_w_ready && !i_done;

    // Beats enter at the top and shift down, so after BEATS beats the first
    // one sits in the least significant nibble. On the final beat the word is
    // taken from this same expression, so the current beat needs no extra
    // cycle.
    assign full_word = {i_r_data, shreg[WM_BAND_WIDTH-1:DOP]};

    // Beat counter and shift register.
    always_ff @(posedge clk) begin
        if (!rst_n || i_done) begin
            nib_cnt <= '0;
            shreg   <= '0;
        end else if (accept) begin
            shreg   <= full_word;
            nib_cnt <= last_beat ? '0 : nib_cnt + NIB_W'(1);
        end
    end

    // Word position within the frame, advanced once per pushed word.
    always_ff @(posedge clk) begin
        if (!rst_n || i_done) begin
            word_cnt <= '0;
        end else if (push) begin
            word_cnt <= (word_cnt == WORD_LAST) ? '0 : word_cnt + WORD_W'(1);
        end
    end

    // Frame-done pulse, raised the cycle after the tagged last word leaves.
    always_ff @(posedge clk) begin
        if (!rst_n || i_done) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= pop && head_last;
        end
    end

    wm_pack_buf #(
        .WIDTH (WM_BAND_WIDTH + 1)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (i_done),
        .push       (push),
        .push_data  ({(word_cnt == WORD_LAST), full_word}),
        .pop        (pop),
        .head_data  ({head_last, head_word}),
        .head_valid (head_valid),
        .full       (buf_full)
    );

    assign o_w_data     = head_word;
    assign o_w_valid    = head_valid;
    assign o_w_last     = head_valid && head_last;
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_wm_pack.sv
// ---------------------------------------------------------------------------
// tb_wm_pack
//
// Self-checking bench for wm_pack. A queue-based model builds each word by
// plain arithmetic from the accepted nibbles and is compared against the DUT
// on every cycle. Directed scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_wm_pack;

    localparam int WB     = 128;
    localparam int DOP    = 4;
    localparam int WM_CNT = 313;
    localparam int BEATS  = WB / DOP;

    localparam logic [WB-1:0] RAMP_WORD = 128'hFEDC_BA98_7654_3210_FEDC_BA98_7654_3210;
    localparam logic [WB-1:0] WORD_A    = {32{4'hA}};
    localparam logic [WB-1:0] WORD_5    = {32{4'h5}};

    logic           clk = 1'b0;
    logic           rst_n;
    logic           i_done;
    logic [DOP-1:0] i_r_data;
    logic           i_wea;
    logic           i_w_ready;
    logic           o_rdy;
    logic [WB-1:0]  o_w_data;
    logic           o_w_valid;
    logic           o_w_last;
    logic           o_frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wm_pack #(
        .WM_BAND_WIDTH (WB),
        .DOP           (DOP),
        .WM_CNT        (WM_CNT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_done       (i_done),
        .i_r_data     (i_r_data),
        .i_wea        (i_wea),
        .o_rdy        (o_rdy),
        .o_w_data     (o_w_data),
        .o_w_valid    (o_w_valid),
        .i_w_ready    (i_w_ready),
        .o_w_last     (o_w_last),
        .o_frame_done (o_frame_done)
    );

    // Count one comparison and report it if it does not hold.
    task automatic checkOutput(input string name, input logic [WB-1:0] act,
                               input logic [WB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, changed on the falling edge.
    task automatic applyStimulus(input logic wea, input logic [DOP-1:0] nib,
                                 input logic wr, input logic dn);
        @(negedge clk);
        i_wea     = wea;
        i_r_data  = nib;
        i_w_ready = wr;
        i_done    = dn;
    endtask

    // Reference model: the buffer is a queue of words with their last flags.
    // A beat is taken when the queue holds fewer than two words; its nibble
    // is added at bit position DOP*beat_index. Every BEATS beats a word is
    // queued, tagged last when it is word WM_CNT-1 of the frame.
    logic [WB-1:0] mq_data[$];
    bit            mq_last[$];
    int            m_beats = 0;
    int            m_words = 0;
    logic [WB-1:0] m_acc   = '0;
    bit            m_fd    = 1'b0;
    bit            chk_en  = 1'b0;

    always @(posedge clk) begin
        bit acc_ok;
        bit pop_ok;
        if (!rst_n || i_done) begin
            mq_data.delete();
            mq_last.delete();
            m_beats = 0;
            m_words = 0;
            m_acc   = '0;
            m_fd    = 1'b0;
        end else begin
            acc_ok = i_wea && (mq_data.size() < 2);
            pop_ok = (mq_data.size() > 0) && i_w_ready;
            m_fd   = pop_ok && mq_last[0];
            if (pop_ok) begin
                void'(mq_data.pop_front());
                void'(mq_last.pop_front());
            end
            if (acc_ok) begin
                m_acc = m_acc | (WB'(i_r_data) << (DOP * m_beats));
                m_beats++;
                if (m_beats == BEATS) begin
                    mq_data.push_back(m_acc);
                    mq_last.push_back(m_words == WM_CNT - 1);
                    m_words = (m_words + 1) % WM_CNT;
                    m_acc   = '0;
                    m_beats = 0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("model_rdy", WB'(o_rdy), WB'(mq_data.size() < 2));
            checkOutput("model_valid", WB'(o_w_valid), WB'(mq_data.size() > 0));
            checkOutput("model_frame_done", WB'(o_frame_done), WB'(m_fd));
            if (mq_data.size() > 0) begin
                checkOutput("model_data", o_w_data, mq_data[0]);
                checkOutput("model_last", WB'(o_w_last), WB'(mq_last[0]));
            end
        end
    end

    // Frame-level counters for the long streaming run.
    bit stream_mon = 1'b0;
    int popped     = 0;
    int last_idx   = 0;
    int n_last     = 0;
    int fd_cnt     = 0;

    always @(negedge clk) begin
        if (stream_mon) begin
            if (o_w_valid && i_w_ready) begin
                popped++;
                if (o_w_last) begin
                    last_idx = popped;
                    n_last++;
                end
            end
            if (o_frame_done) begin
                fd_cnt++;
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        i_done    = 1'b0;
        i_wea     = 1'b0;
        i_r_data  = '0;
        i_w_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("reset_valid", WB'(o_w_valid), '0);
        checkOutput("reset_last", WB'(o_w_last), '0);
        checkOutput("reset_frame_done", WB'(o_frame_done), '0);
        checkOutput("reset_data", o_w_data, '0);
        checkOutput("reset_rdy", WB'(o_rdy), WB'(1));
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Ramp word, latency of one cycle after the final beat
        for (int k = 0; k < BEATS; k++) begin
            applyStimulus(1'b1, DOP'(k), 1'b1, 1'b0);
            if (k == BEATS - 1) begin
                checkOutput("ramp_not_early", WB'(o_w_valid), '0);
            end
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("ramp_valid", WB'(o_w_valid), WB'(1));
        checkOutput("ramp_data", o_w_data, RAMP_WORD);
        checkOutput("ramp_last", WB'(o_w_last), '0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("ramp_popped", WB'(o_w_valid), '0);

        // Back-pressure: fill both entries, extra beats are ignored
        for (int k = 0; k < 2 * BEATS; k++) begin
            applyStimulus(1'b1, (k < BEATS) ? 4'hA : 4'h5, 1'b0, 1'b0);
            if (k == BEATS + 1) begin
                checkOutput("bp_rdy_one_entry", WB'(o_rdy), WB'(1));
            end
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
            checkOutput("bp_rdy_full", WB'(o_rdy), '0);
            checkOutput("bp_head_a", o_w_data, WORD_A);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("bp_rdy_before_pop", WB'(o_rdy), '0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("bp_rdy_after_pop", WB'(o_rdy), WB'(1));
        checkOutput("bp_head_5", o_w_data, WORD_5);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("bp_drained", WB'(o_w_valid), '0);

        // Abort after 17 beats, next word uses only fresh beats
        for (int k = 0; k < 17; k++) begin
            applyStimulus(1'b1, 4'hF, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        for (int k = 0; k < BEATS; k++) begin
            applyStimulus(1'b1, DOP'(k), 1'b1, 1'b0);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("abort_valid", WB'(o_w_valid), WB'(1));
        checkOutput("abort_fresh_data", o_w_data, RAMP_WORD);

        // Abort together with a final beat and a pop
        for (int k = 0; k < BEATS; k++) begin
            applyStimulus(1'b1, 4'h3, 1'b0, 1'b0);
        end
        for (int k = 0; k < BEATS - 1; k++) begin
            applyStimulus(1'b1, 4'h7, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 4'h7, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("clash_valid", WB'(o_w_valid), '0);
        checkOutput("clash_rdy", WB'(o_rdy), WB'(1));
        checkOutput("clash_frame_done", WB'(o_frame_done), '0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("clash_frame_done_later", WB'(o_frame_done), '0);

        // Full frame streamed at line rate
        i_w_ready  = 1'b1;
        stream_mon = 1'b1;
        for (int k = 0; k < WM_CNT * BEATS; k++) begin
            applyStimulus(1'b1, DOP'($urandom_range(0, 15)), 1'b1, 1'b0);
        end
        repeat (4) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        stream_mon = 1'b0;
        checkOutput("frame_words", WB'(popped), WB'(WM_CNT));
        checkOutput("frame_last_pos", WB'(last_idx), WB'(WM_CNT));
        checkOutput("frame_last_count", WB'(n_last), WB'(1));
        checkOutput("frame_done_count", WB'(fd_cnt), WB'(1));

        // First word of the next frame is not tagged last
        for (int k = 0; k < BEATS; k++) begin
            applyStimulus(1'b1, DOP'(k), 1'b0, 1'b0);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("next_frame_valid", WB'(o_w_valid), WB'(1));
        checkOutput("next_frame_last", WB'(o_w_last), '0);

        // Reset mid-frame with one word buffered and a partial word
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 4'h2, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b0;
        i_wea = 1'b0;
        @(negedge clk);
        checkOutput("midrst_valid", WB'(o_w_valid), '0);
        checkOutput("midrst_last", WB'(o_w_last), '0);
        checkOutput("midrst_frame_done", WB'(o_frame_done), '0);
        checkOutput("midrst_data", o_w_data, '0);
        checkOutput("midrst_rdy", WB'(o_rdy), WB'(1));
        rst_n = 1'b1;

        // Packing restarts cleanly after reset
        for (int k = 0; k < BEATS; k++) begin
            applyStimulus(1'b1, DOP'(k), 1'b1, 1'b0);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("postrst_data", o_w_data, RAMP_WORD);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wm_pack.md
WM_PACK -- requirements
Module: wm_pack

Interface
REQ-001 Parameter WM_BAND_WIDTH, default 128: width of one packed watermark word.
REQ-002 Parameter DOP, default 4: nibble (lane) width per input beat; WM_BAND_WIDTH/DOP (default 32) beats form one word.
REQ-003 Parameter WM_CNT, default 313: words per watermark frame.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 i_done  input  1  synchronous frame abort/clear.
REQ-007 i_r_data  input  DOP  extracted watermark nibble.
REQ-008 i_wea  input  1  i_r_data valid.
REQ-009 o_rdy  output  1  nibble accept ready; a beat is accepted when i_wea && o_rdy.
REQ-010 o_w_data  output  WM_BAND_WIDTH  packed word at buffer head.
REQ-011 o_w_valid  output  1  o_w_data valid.
REQ-012 i_w_ready  input  1  downstream ready; a word is popped when o_w_valid && i_w_ready.
REQ-013 o_w_last  output  1  head word is word WM_CNT-1 of the frame (qualified by o_w_valid).
REQ-014 o_frame_done  output  1  one-cycle pulse on the cycle after the last word of a frame is popped.

Function
REQ-015 Nibble packing SHALL be LSB-first: the k-th accepted beat of a word (k=0..31) lands in bits [DOP*k+DOP-1 : DOP*k].
REQ-016 Beat counter nib_cnt SHALL count 0..WM_BAND_WIDTH/DOP-1, increment per accepted beat, and wrap to 0 on the final beat.
REQ-017 On the final beat, the complete word (shift register contents plus the current beat) SHALL be written into the output buffer in the same cycle; o_w_valid rises the next cycle (latency 1 clk from last-beat accept).
REQ-018 Output buffer SHALL be a 2-entry FIFO of {word, last flag}; o_w_data/o_w_last/o_w_valid show the head entry.
REQ-019 o_rdy SHALL be 0 when the buffer holds 2 entries, else 1; a simultaneous pop does not raise o_rdy in that cycle.
REQ-020 Simultaneous push and pop SHALL keep the buffer occupancy unchanged and preserve order.
REQ-021 Word counter SHALL count 0..WM_CNT-1 per pushed word and wrap to 0 after word WM_CNT-1; that word's last flag SHALL be 1, all others 0.
REQ-022 o_frame_done SHALL pulse exactly once per popped word carrying last flag = 1.
REQ-023 i_done SHALL, on the next edge, clear nib_cnt, shift register, word counter, buffer occupancy and o_frame_done; it SHALL take priority over a simultaneous accept or pop, and the partial word is discarded.
REQ-024 i_wea while o_rdy = 0 SHALL be ignored with no state change (the sender must hold the beat).

Reset
REQ-025 With rst_n = 0 at a clock edge: o_w_valid=0, o_w_last=0, o_frame_done=0, o_w_data=0, o_rdy=1, all counters 0.
REQ-026 Reset mid-word or mid-frame SHALL behave identically to i_done, plus zeroing the buffer data.

Structure
REQ-027 WM_BAND_WIDTH, DOP, WM_CNT defaults and the clog2 function SHALL live in a shared watermark package used by wm_pack and the read-side nibble unpacker.
REQ-028 The 2-entry output buffer SHALL be one sub-module, wm_pack_buf, parameterised by data width.
REQ-029 Counter widths SHALL be derived as clog2(N-1) of each count range.

Verification
REQ-030 Feed 32 beats with nibble value k (mod 16) for beat k, i_w_ready=1 -> one word 0xFEDC_BA98_7654_3210_FEDC_BA98_7654_3210, o_w_valid 1 cycle after beat 31, o_w_last=0.
REQ-031 Stream 313*32 beats continuously with i_w_ready=1 -> 313 words, o_w_last only on word 313, one o_frame_done pulse, word counter back to 0.
REQ-032 i_w_ready=0, push 2 words -> o_rdy=0 after second push, extra i_wea beats ignored; raise i_w_ready -> words pop in order, o_rdy returns 1 the cycle after first pop.
REQ-033 Assert i_done after 17 beats of a word -> next word is built from fresh beats only, word counter restarts at 0.
REQ-034 Assert i_done in the same cycle as final-beat accept and a pop -> buffer empty, no word pushed, o_frame_done=0.
REQ-035 Drive rst_n=0 for one cycle mid-frame with 1 word buffered -> all outputs at REQ-025 values on the next edge.
